// File: rtl/nn_arith_pkg.sv
// Shared arithmetic constants for the neural-network datapath.
// The multiplier product width and operand width set the divider's
// default dividend/quotient and divisor/remainder widths.
package nn_arith_pkg;

    localparam int NN_PROD_W = 16;
    localparam int NN_OPND_W = 8;

    // Quotient returned when the divisor is zero (saturated, all ones)
    localparam logic [NN_PROD_W-1:0] NN_DIV_SAT = {NN_PROD_W{1'b1}};

endpackage

// File: rtl/div_step_stage.sv
// One restoring-division step plus its pipeline registers.
// The dq field is a single shift register: its MSB is the next dividend
// bit to consume, and each step shifts the new quotient bit in at the LSB.
// After DW_N steps it holds the complete quotient.
module div_step_stage
    import nn_arith_pkg::*;
#(
    parameter int DW_N = NN_PROD_W,
    parameter int DW_D = NN_OPND_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            in_valid,
    input  logic            in_zero,
    input  logic [DW_D-1:0] in_dsr,
    input  logic [DW_D-1:0] in_rem,
    input  logic [DW_N-1:0] in_dq,
    output logic            out_valid,
    output logic            out_zero,
    output logic [DW_D-1:0] out_dsr,
    output logic [DW_D-1:0] out_rem,
    output logic [DW_N-1:0] out_dq
);

    logic [DW_D:0]   r_shift;
    logic            q_bit;
    logic [DW_D-1:0] rem_next;

    // Shift in the next dividend bit, compare against divisor, restore or subtract.
    // When q_bit is 0 the shifted remainder is below an 8-bit divisor, so its top bit is 0.
    always_comb begin
        r_shift  = {in_rem, in_dq[DW_N-1]};
        q_bit    = (r_shift >= {1'b0, in_dsr});
        rem_next = q_bit ? DW_D'(r_shift - {1'b0, in_dsr}) : r_shift[DW_D-1:0];
    end

    // Stage registers; frozen whenever the pipeline does not advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_zero  <= 1'b0;
            out_dsr   <= '0;
            out_rem   <= '0;
            out_dq    <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_zero  <= in_zero;
            out_dsr   <= in_dsr;
            out_rem   <= rem_next;
            out_dq    <= {in_dq[DW_N-2:0], q_bit};
        end
    end

endmodule

// File: rtl/div16x8_piped.sv
// Fully pipelined unsigned restoring divider, one quotient bit per stage,
// one operation accepted and one result produced per cycle.
// Optional build macro: DIV_ZERO_FLAG_EN adds the div_zero output flag.
// A zero divisor always yields quotient all-ones and remainder 0.
module div16x8_piped
    import nn_arith_pkg::*;
#(
    parameter int DW_N = NN_PROD_W,
    parameter int DW_D = NN_OPND_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_N-1:0] dividend,
    input  logic [DW_D-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_N-1:0] quotient,
    output logic [DW_D-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic            div_zero
`endif
);

    logic            adv;
    logic            s_valid [0:DW_N];
    logic            s_zero  [0:DW_N];
    logic [DW_D-1:0] s_dsr   [0:DW_N];
    logic [DW_D-1:0] s_rem   [0:DW_N];
    logic [DW_N-1:0] s_dq    [0:DW_N];

    // Whole pipeline advances unless a finished result is being held back.
    always_comb begin
        adv      = !out_valid || out_ready;
        in_ready = adv;
    end

    assign s_valid[0] = in_valid;
    assign s_zero[0]  = (divisor == '0);
    assign s_dsr[0]   = divisor;
    assign s_rem[0]   = '0;
    assign s_dq[0]    = dividend;

    for (genvar i = 0; i < DW_N; i++) begin : g_stage
        div_step_stage #(
            .DW_N (DW_N),
            .DW_D (DW_D)
        ) u_step (
            .clk       (clk),
            .reset     (reset),
            .en        (adv),
            .in_valid  (s_valid[i]),
            .in_zero   (s_zero[i]),
            .in_dsr    (s_dsr[i]),
            .in_rem    (s_rem[i]),
            .in_dq     (s_dq[i]),
            .out_valid (s_valid[i+1]),
            .out_zero  (s_zero[i+1]),
            .out_dsr   (s_dsr[i+1]),
            .out_rem   (s_rem[i+1]),
            .out_dq    (s_dq[i+1])
        );
    end

    // Output register: data only changes when a real result moves in, so a
    // bubble never disturbs the last presented values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero  <= 1'b0;
`endif
        end else if (adv) begin
            out_valid <= s_valid[DW_N];
            if (s_valid[DW_N]) begin
                quotient  <= s_zero[DW_N] ? {DW_N{1'b1}} : s_dq[DW_N];
                remainder <= s_zero[DW_N] ? '0 : s_rem[DW_N];
`ifdef DIV_ZERO_FLAG_EN
                div_zero  <= s_zero[DW_N];
`endif
            end
        end
    end

endmodule

// File: tb/tb_div16x8_piped.sv
// Self-checking bench for div16x8_piped: a driver pushes the expected
// result into a scoreboard when an operand is accepted, and a monitor
// pops and compares every result the divider hands over.
module tb_div16x8_piped;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    int   pop_q[$];

    div16x8_piped dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t ref_div(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q = 16'hFFFF;
            e.r = 8'd0;
            e.z = 1'b1;
        end else begin
            e.q = a / {8'd0, b};
            e.r = 8'(a % {8'd0, b});
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Present an operand from a falling edge and hold it until accepted.
    task automatic send(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        e = ref_div(a, b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            #4;
            if (in_ready) begin
                @(posedge clk);
                exp_q.push_back(e);
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Cycles from the accepting edge until out_valid is seen high.
    task automatic latency(input string name);
        int lat;
        lat = -1;
        idle();
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        chk(name, lat, 16);
    endtask

    // Monitor: sample just before the rising edge; a handshake there is a transfer.
    always begin
        exp_t e;
        @(negedge clk);
        #4;
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {quotient, remainder}, 32'd0);
                if ({quotient, remainder} === 24'd0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got out_valid=1 expected no result");
                end
            end else begin
                e = exp_q.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
`ifdef DIV_ZERO_FLAG_EN
                chk("div_zero", div_zero, e.z);
`endif
                pop_q.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end expected end of test");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        reset     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #4;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_in_ready", in_ready, 1);

        // Basic operation and latency
        send(16'd30000, 8'd150);
        latency("latency_basic");
        drain();

        // Corners, back to back
        send(16'hFFFF, 8'd1);
        send(16'h0000, 8'hFF);
        send(16'd1000, 8'd7);
        send(16'hFFFF, 8'hFF);
        idle();
        drain();

        // Divide by zero
        send(16'h1234, 8'd0);
        idle();
        drain();

        // 32 back-to-back ops, one result per cycle
        pop_q.delete();
        for (int i = 0; i < 32; i++)
            send(16'($urandom_range(0, 65535)), (i % 11 == 5) ? 8'd0 : 8'($urandom_range(1, 255)));
        idle();
        drain();
        chk("stream_count", pop_q.size(), 32);
        if (pop_q.size() == 32)
            chk("stream_spacing", pop_q[31] - pop_q[0], 31);

        // Backpressure: results pile up, then stall for 5 cycles with an operand waiting
        @(negedge clk);
        out_ready = 1'b0;
        send(16'd100, 8'd3);
        send(16'd50000, 8'd200);
        send(16'd12345, 8'd99);
        send(16'd255, 8'd16);
        idle();
        repeat (20) @(negedge clk);
        fork
            send(16'd60000, 8'd250);
            begin
                repeat (5) begin
                    @(negedge clk);
                    #4;
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_quotient", quotient, 16'd33);
                    chk("stall_remainder", remainder, 8'd1);
                end
                chk("stall_not_consumed", exp_q.size(), 4);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle();
        drain();

        // Reset with operations in flight
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            send(16'(1000 * i + 77), 8'(i + 3));
        idle();
        repeat (20) @(negedge clk);
        #4;
        chk("pre_reset_valid", out_valid, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_async_valid", out_valid, 0);
        exp_q.delete();
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            #4;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("no_stale_result", seen, 0);
        send(16'd777, 8'd10);
        latency("latency_after_reset");
        drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
